// File: rtl/step_pulse_tracker.sv
// Step/dir receiver: synchronises step and dir, validates pulse width and spacing,
// and keeps a signed position count with at-target detection.
module step_pulse_tracker #(
    parameter int unsigned           POS_W      = 16,
    parameter int unsigned           CNT_W      = 28,
    parameter logic [CNT_W-1:0]      MIN_HIGH   = CNT_W'(1000),
    parameter logic [CNT_W-1:0]      MIN_PERIOD = CNT_W'(1000000)
) (
    input  logic             clock_in,
    input  logic             resetn,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             clear,
    input  logic [POS_W-1:0] target,
    output logic [POS_W-1:0] position,
    output logic             step_strobe,
    output logic             at_target,
    output logic             busy,
    output logic             err_short,
    output logic             err_fast
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HIGH   = 2'd1;
    localparam logic [1:0] REJECT = 2'd2;

    logic             step_meta, s_step;
    logic             dir_meta, s_dir;
    logic [1:0]       state_q, state_nxt;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_nxt;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_nxt;
    logic             pulse_seen_q, pulse_seen_nxt;
    logic             dir_q, dir_nxt;
    logic [POS_W-1:0] position_nxt;
    logic             strobe_nxt, err_short_nxt, err_fast_nxt;
    logic             period_ok;

    // No accepted pulse since reset/clear means the period check is waived.
    assign period_ok = !pulse_seen_q || (period_cnt_q >= MIN_PERIOD);

    // Two-flop synchronisers for the asynchronous step/dir lines.
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            step_meta <= 1'b0;
            s_step    <= 1'b0;
            dir_meta  <= 1'b0;
            s_dir     <= 1'b0;
        end else begin
            step_meta <= step_in;
            s_step    <= step_meta;
            dir_meta  <= dir_in;
            s_dir     <= dir_meta;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            pulse_seen_q <= 1'b0;
            dir_q        <= 1'b0;
            position     <= '0;
            step_strobe  <= 1'b0;
            at_target    <= 1'b0;
            busy         <= 1'b0;
            err_short    <= 1'b0;
            err_fast     <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            high_cnt_q   <= high_cnt_nxt;
            period_cnt_q <= period_cnt_nxt;
            pulse_seen_q <= pulse_seen_nxt;
            dir_q        <= dir_nxt;
            position     <= position_nxt;
            step_strobe  <= strobe_nxt;
            at_target    <= (position == target);
            busy         <= (state_nxt != IDLE);
            err_short    <= err_short_nxt;
            err_fast     <= err_fast_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt      = state_q;
        high_cnt_nxt   = high_cnt_q;
        period_cnt_nxt = (period_cnt_q < MIN_PERIOD) ? period_cnt_q + CNT_W'(1) : period_cnt_q;
        pulse_seen_nxt = pulse_seen_q;
        dir_nxt        = dir_q;
        position_nxt   = position;
        strobe_nxt     = 1'b0;
        err_short_nxt  = err_short;
        err_fast_nxt   = err_fast;

        if (clear) begin
            // A pulse in progress at clear is discarded by parking in REJECT.
            position_nxt   = '0;
            err_short_nxt  = 1'b0;
            err_fast_nxt   = 1'b0;
            pulse_seen_nxt = 1'b0;
            period_cnt_nxt = '0;
            high_cnt_nxt   = '0;
            state_nxt      = s_step ? REJECT : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_step) begin
                        if (period_ok) begin
                            state_nxt      = HIGH;
                            dir_nxt        = s_dir;
                            high_cnt_nxt   = CNT_W'(1);
                            period_cnt_nxt = '0;
                            pulse_seen_nxt = 1'b1;
                        end else begin
                            state_nxt    = REJECT;
                            err_fast_nxt = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (s_step) begin
                        if (high_cnt_q < MIN_HIGH) begin
                            high_cnt_nxt = high_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_nxt = IDLE;
                        if (high_cnt_q >= MIN_HIGH) begin
                            position_nxt = dir_q ? position + POS_W'(1) : position - POS_W'(1);
                            strobe_nxt   = 1'b1;
                        end else begin
                            err_short_nxt = 1'b1;
                        end
                    end
                end
                REJECT: begin
                    if (!s_step) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_tracker.sv
// Directed bench for step_pulse_tracker with MIN_HIGH=4, MIN_PERIOD=20.
module tb_step_pulse_tracker;

    logic        clk = 1'b0;
    logic        resetn;
    logic        step_in;
    logic        dir_in;
    logic        clear;
    logic [15:0] target;
    logic [15:0] position;
    logic        step_strobe;
    logic        at_target;
    logic        busy;
    logic        err_short;
    logic        err_fast;

    int total = 0;
    int passed = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    step_pulse_tracker #(
        .POS_W     (16),
        .CNT_W     (28),
        .MIN_HIGH  (28'd4),
        .MIN_PERIOD(28'd20)
    ) dut (
        .clock_in   (clk),
        .resetn     (resetn),
        .step_in    (step_in),
        .dir_in     (dir_in),
        .clear      (clear),
        .target     (target),
        .position   (position),
        .step_strobe(step_strobe),
        .at_target  (at_target),
        .busy       (busy),
        .err_short  (err_short),
        .err_fast   (err_fast)
    );

    always @(negedge clk) begin
        if (resetn === 1'b1 && step_strobe === 1'b1) strobes++;
    end

    typedef struct {
        logic        dir;
        int          high;
        int          low;
        logic        flip;
        logic [15:0] pos;
        logic        e_short;
        logic        e_fast;
        int          n_strobe;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else passed++;
    endtask

    // Drives one pulse: high for h cycles then low for l cycles, from a negedge.
    task automatic pulse(input logic d, input int h, input int l, input logic flip);
        step_in = 1'b1;
        dir_in  = d;
        for (int i = 0; i < h; i++) begin
            if (flip && i == 2) dir_in = ~d;
            @(negedge clk);
        end
        step_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    initial begin
        logic found;
        int   lat;

        vecs[0] = '{1'b1, 6, 19, 1'b0, 16'd1, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b1, 6, 19, 1'b0, 16'd2, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b1, 6, 19, 1'b0, 16'd3, 1'b0, 1'b0, 1};
        vecs[3] = '{1'b1, 2, 23, 1'b0, 16'd3, 1'b1, 1'b0, 0};
        vecs[4] = '{1'b1, 6, 19, 1'b1, 16'd4, 1'b1, 1'b0, 1};
        vecs[5] = '{1'b0, 4, 21, 1'b0, 16'd3, 1'b1, 1'b0, 1};
        vecs[6] = '{1'b1, 3, 22, 1'b0, 16'd3, 1'b1, 1'b0, 0};
        vecs[7] = '{1'b1, 6,  4, 1'b0, 16'd4, 1'b1, 1'b0, 1};
        vecs[8] = '{1'b1, 6, 19, 1'b0, 16'd4, 1'b1, 1'b1, 0};
        vecs[9] = '{1'b1, 6, 19, 1'b0, 16'd5, 1'b1, 1'b1, 1};

        resetn  = 1'b0;
        step_in = 1'b1;
        dir_in  = 1'b1;
        clear   = 1'b0;
        target  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_position", 32'(position), 32'h0);
        chk("rst_strobe", 32'(step_strobe), 32'h0);
        chk("rst_at_target", 32'(at_target), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err_short", 32'(err_short), 32'h0);
        chk("rst_err_fast", 32'(err_fast), 32'h0);

        step_in = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);

        for (int v = 0; v < 10; v++) begin
            strobes = 0;
            pulse(vecs[v].dir, vecs[v].high, vecs[v].low, vecs[v].flip);
            chk($sformatf("v%0d_position", v), 32'(position), 32'(vecs[v].pos));
            chk($sformatf("v%0d_err_short", v), 32'(err_short), 32'(vecs[v].e_short));
            chk($sformatf("v%0d_err_fast", v), 32'(err_fast), 32'(vecs[v].e_fast));
            chk($sformatf("v%0d_strobes", v), 32'(strobes), 32'(vecs[v].n_strobe));
        end

        // Clear from a quiet line zeroes everything; at_target follows.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk("clr_position", 32'(position), 32'h0);
        chk("clr_err_short", 32'(err_short), 32'h0);
        chk("clr_err_fast", 32'(err_fast), 32'h0);
        chk("clr_at_target", 32'(at_target), 32'h1);

        // Downward wrap, 3-edge latency, and at_target one cycle behind position.
        target  = 16'hFFFF;
        step_in = 1'b1;
        dir_in  = 1'b0;
        repeat (6) @(negedge clk);
        step_in = 1'b0;
        found = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (step_strobe === 1'b1) found = 1'b1;
        end
        chk("wrap_strobe_seen", 32'(found), 32'h1);
        chk("wrap_latency", 32'(lat), 32'd3);
        chk("wrap_position", 32'(position), 32'hFFFF);
        chk("wrap_at_target_early", 32'(at_target), 32'h0);
        @(negedge clk);
        chk("wrap_at_target", 32'(at_target), 32'h1);
        chk("wrap_strobe_one_cycle", 32'(step_strobe), 32'h0);

        // Clear while step is high discards the pulse and the sticky error.
        repeat (25) @(negedge clk);
        pulse(1'b1, 2, 23, 1'b0);
        chk("pre_clr_err_short", 32'(err_short), 32'h1);
        strobes = 0;
        step_in = 1'b1;
        dir_in  = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_busy_high", 32'(busy), 32'h1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_reject", 32'(busy), 32'h1);
        step_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_position", 32'(position), 32'h0);
        chk("mid_err_short", 32'(err_short), 32'h0);
        chk("mid_err_fast", 32'(err_fast), 32'h0);
        chk("mid_strobes", 32'(strobes), 32'h0);
        chk("mid_busy_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
